// File: rtl/pong_timing_pkg.sv
// Shared Pong video timing definitions: sequencer state encodings, the
// default line/frame geometry and a small window-decode helper.
package pong_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DRAIN  = 2'b10
    } state_t;

    localparam int CNT_W   = 9;
    localparam int CNT_MAX = 512;

    localparam int PONG_H_TOTAL      = 455;
    localparam int PONG_V_TOTAL      = 262;
    localparam int PONG_H_BLANK_END  = 80;
    localparam int PONG_H_SYNC_START = 32;
    localparam int PONG_H_SYNC_END   = 64;
    localparam int PONG_V_BLANK_END  = 16;
    localparam int PONG_V_SYNC_START = 4;
    localparam int PONG_V_SYNC_END   = 8;

    // True when lo <= pos < hi.
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Clock-enabled horizontal/vertical position counter pair. Wraps at the end
// of each line and frame, exposes end-of-line / end-of-frame decodes and
// holds at 0,0 while clear is asserted.
module frame_pos_counter
    import pong_timing_pkg::*;
#(
    parameter int H_TOTAL = PONG_H_TOTAL,
    parameter int V_TOTAL = PONG_V_TOTAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             eol,
    output logic             eof
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] vcnt_r;
    logic             eol_s;
    logic             eof_s;

    // Last-pixel decodes taken straight from the registered position.
    always_comb begin
        eol_s = (hcnt_r == H_LAST);
        eof_s = eol_s && (vcnt_r == V_LAST);
    end

    // Position registers: advance on enabled pixel clocks, wrap per line and frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r <= '0;
            vcnt_r <= '0;
        end else if (clear) begin
            hcnt_r <= '0;
            vcnt_r <= '0;
        end else if (en && ce) begin
            if (eol_s) begin
                hcnt_r <= '0;
                if (eof_s) begin
                    vcnt_r <= '0;
                end else begin
                    vcnt_r <= vcnt_r + CNT_W'(1);
                end
            end else begin
                hcnt_r <= hcnt_r + CNT_W'(1);
            end
        end
    end

    assign hcnt = hcnt_r;
    assign vcnt = vcnt_r;
    assign eol  = eol_s;
    assign eof  = eof_s;

endmodule

// File: rtl/frame_timing_ctrl.sv
// Pong frame sequencer: run/hold/single-step FSM around the h/v position
// counter, frame strobes, completed-frame counter and blank/sync decodes.
// Outside IDLE a frame always runs to its last pixel before the sequencer
// can stop, so the game freezes only on a frame boundary.
module frame_timing_ctrl
    import pong_timing_pkg::*;
#(
    parameter int H_TOTAL      = PONG_H_TOTAL,
    parameter int V_TOTAL      = PONG_V_TOTAL,
    parameter int H_BLANK_END  = PONG_H_BLANK_END,
    parameter int H_SYNC_START = PONG_H_SYNC_START,
    parameter int H_SYNC_END   = PONG_H_SYNC_END,
    parameter int V_BLANK_END  = PONG_V_BLANK_END,
    parameter int V_SYNC_START = PONG_V_SYNC_START,
    parameter int V_SYNC_END   = PONG_V_SYNC_END
) (
    input  logic             clk7_159,
    input  logic             _reset,
    input  logic             ce,
    input  logic             run,
    input  logic             step,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hreset,
    output logic             vreset,
    output logic             _vreset,
    output logic             hblank,
    output logic             vblank,
    output logic             _hsync,
    output logic             _vsync,
    output logic             frame_start,
    output logic [7:0]       frame_cnt,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HB_END   = CNT_W'(H_BLANK_END);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] VB_END   = CNT_W'(V_BLANK_END);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC_END);

    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_geometry
        $error("frame_timing_ctrl: H_TOTAL and V_TOTAL must lie in 2..512");
    end

    state_t           state_r;
    state_t           state_next_s;
    logic             counting_s;
    logic             leave_idle_s;
    logic             eof_ce_s;
    logic             eol_s;
    logic             eof_s;
    logic [CNT_W-1:0] hcnt_s;
    logic [CNT_W-1:0] vcnt_s;
    logic             start_pending_r;
    logic             frame_start_r;
    logic [7:0]       frame_cnt_r;

    frame_pos_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_pos (
        .clk   (clk7_159),
        .rst_n (_reset),
        .ce    (ce),
        .en    (counting_s),
        .clear (!counting_s),
        .hcnt  (hcnt_s),
        .vcnt  (vcnt_s),
        .eol   (eol_s),
        .eof   (eof_s)
    );

    // Qualifiers shared by the FSM and the frame strobes.
    always_comb begin
        counting_s   = (state_r == ST_ACTIVE) || (state_r == ST_DRAIN);
        eof_ce_s     = counting_s && ce && eof_s;
        leave_idle_s = (state_r == ST_IDLE) && (run || step);
    end

    // Next-state logic: run always wins; without run a frame drains to its end.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_next_s = ST_ACTIVE;
                end else if (step) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE, ST_DRAIN: begin
                if (run) begin
                    state_next_s = ST_ACTIVE;
                end else if (eof_ce_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame strobes: start pulse on the first enabled clock of a new frame
    // (a start requested while ce=0 is held until the next enabled clock),
    // and the completed-frame count on every counted end of frame.
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            start_pending_r <= 1'b0;
            frame_start_r   <= 1'b0;
            frame_cnt_r     <= 8'd0;
        end else begin
            frame_start_r <= (ce && (leave_idle_s || start_pending_r)) || (eof_ce_s && run);
            if (leave_idle_s && !ce) begin
                start_pending_r <= 1'b1;
            end else if (ce) begin
                start_pending_r <= 1'b0;
            end
            if (eof_ce_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
        end
    end

    // Line/frame strobes, blanking and sync decoded from registered state; IDLE forces blank.
    always_comb begin
        hreset = 1'b0;
        vreset = 1'b0;
        hblank = 1'b1;
        vblank = 1'b1;
        _hsync = 1'b1;
        _vsync = 1'b1;
        if (counting_s) begin
            hreset = eol_s;
            vreset = (vcnt_s == V_LAST);
            hblank = (hcnt_s < HB_END);
            vblank = (vcnt_s < VB_END);
            _hsync = !in_window(hcnt_s, HS_START, HS_END);
            _vsync = !in_window(vcnt_s, VS_START, VS_END);
        end else begin
            hreset = 1'b0;
            vreset = 1'b0;
        end
        _vreset = !vreset;
    end

    assign hcnt        = hcnt_s;
    assign vcnt        = vcnt_s;
    assign frame_start = frame_start_r;
    assign frame_cnt   = frame_cnt_r;
    assign state       = state_r;

endmodule
